branch_hazard_controller: RTL and testbench
===========================================

# branch_hazard_controller

Sequences the ID-stage branch/jump resolution path of the 5-stage pipeline. It detects when a branch in ID needs an operand that is still in flight. It stalls PC and IF/ID for the right number of cycles and selects comparator forwarding sources. It qualifies the equality comparator's taken signal and issues the IF/ID flush. It also keeps saturating taken-branch and stall-cycle counters for performance monitoring.

## Interface
- CNT_W, 16, width of both performance counters
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- id_branch  in  2  bit0 = BEQ, bit1 = BNE (from control unit)
- id_jump  in  1  J/JAL in ID
- id_rs, id_rt  in  5  branch source registers in ID
- ex_reg_write, ex_mem_read  in  1  ID/EX control of instruction in EX
- ex_rd  in  5  EX destination register
- mem_reg_write, mem_mem_read  in  1  EX/MEM control
- mem_rd  in  5  MEM destination register
- wb_reg_write  in  1  MEM/WB control
- wb_rd  in  5  WB destination register
- cmp_taken  in  1  raw taken result from the branch/jump detection comparator
- cnt_clear  in  1  synchronous clear of both counters
- pc_write  out  1  PC load enable
- if_id_write  out  1  IF/ID load enable
- id_ex_bubble  out  1  zero the control fields entering ID/EX
- if_id_flush  out  1  replace IF/ID contents with a NOP at next edge
- pc_sel_branch  out  1  PC mux selects branch target (qualified taken)
- fwd_a, fwd_b  out  2  comparator operand source: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB write data
- taken_cnt, stall_cnt  out  CNT_W  performance counters

## Operation
- Branch active = id_branch != 0 && !id_jump. Jump takes priority over branch.
- Hazard per source register r (r != 0, r used by the branch):
  - EX writes r with a load: needs 2 stall cycles.
  - EX writes r with an ALU op: needs 1 stall cycle.
  - MEM load writes r: needs 1 stall cycle.
  - Required stall n = maximum over rs and rt.
- FSM states:
  - RUN: If branch active and n > 0, stall this cycle. Go to STALL when n = 2, or to RESOLVE when n = 1. Otherwise remain in RUN and resolve in this cycle.
  - STALL: Stall this cycle, then go to RESOLVE.
  - RESOLVE: No stall, resolve this cycle, then go to RUN.
- Stall cycle outputs: pc_write=0, if_id_write=0, id_ex_bubble=1, pc_sel_branch=0, if_id_flush=0.
- Resolve cycle (branch active, not stalling): pc_sel_branch = cmp_taken, if_id_flush = cmp_taken.
- Jump in RUN: if_id_flush=1, no stall, pc_sel_branch=0 (the jump mux is owned elsewhere).
- Forwarding, computed per operand every cycle:
  - 01 if mem_reg_write && !mem_mem_read && mem_rd == r && r != 0.
  - Otherwise 10 if wb_reg_write && wb_rd == r && r != 0.
  - Otherwise 00.
  - EX/MEM has priority over MEM/WB.
- Counters:
  - taken_cnt increments on each qualified taken branch.
  - stall_cnt increments on each stall cycle.
  - Both saturate at all-ones.
  - cnt_clear wins over a simultaneous increment.

## Timing
- Outputs are combinational (Mealy) from the state register and the current inputs. The state and counters are registered.
- Latency:
  - Taken branch with no hazard: flush asserted in the same cycle, 1-cycle penalty.
  - ALU-producer hazard: 1 stall cycle plus the flush.
  - Load in EX: 2 stall cycles.
- Reset (rst_n low at a rising edge): state goes to RUN and counters go to 0.
- Outputs while rst_n is low: pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=0, pc_sel_branch=0, fwd_a=fwd_b=00.
- Reset during STALL or RESOLVE abandons the sequence with no flush.
- If the branch deasserts in STALL or RESOLVE (external flush), the FSM still completes to RUN. pc_sel_branch is gated by branch active.
- Non-branch instructions never stall here. Load-use hazards for ALU ops belong to the general hazard unit.

## Structure
- Shared pipeline package: FSM state encoding (RUN=2'd0, STALL=2'd1, RESOLVE=2'd2) and forwarding select constants FWD_RF, FWD_EXMEM, FWD_MEMWB.
- One natural sub-module: branch_fwd_sel, the per-operand forwarding/hazard evaluator. It is instantiated twice (rs, rt) and returns fwd select plus stall need.

## Test plan
- BEQ $1,$2 with no in-flight writers, cmp_taken=1 -> same cycle: if_id_flush=1, pc_sel_branch=1, no stall; taken_cnt 0->1.
- ADD writes $3 in EX, BNE $3,$4 in ID -> 1 stall cycle. Next cycle RESOLVE has fwd_a=01; with cmp_taken=0 there is no flush. stall_cnt=1.
- LW writes $5 in EX, BEQ $5,$0 -> 2 stall cycles with id_ex_bubble=1. Then fwd_a=10 in RESOLVE; cmp_taken=1 gives a flush. stall_cnt=2.
- id_jump=1 together with id_branch=01 and an EX hazard on rs -> no stall, if_id_flush=1, pc_sel_branch=0.
- Hazard with ex_rd=0 on $0 operands -> no stall, fwd=00.
- rst_n low during STALL -> next cycle state is RUN, counters 0. Counter at 16'hFFFF plus a stall holds at FFFF. cnt_clear with a simultaneous increment -> 0.

Source files
------------

// File: rtl/branch_hazard_controller_pkg.sv
// Shared definitions for the ID-stage branch hazard controller: FSM encoding,
// comparator forwarding selects and a small stall-need helper.
package branch_hazard_controller_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        STALL   = 2'd1,
        RESOLVE = 2'd2
    } bhc_state_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    function automatic logic [1:0] max_need(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/branch_hazard_controller_if.sv
// Pipeline-side bundle of the branch hazard controller; the pipeline (master)
// drives ID/EX/MEM/WB status, the controller (slave) returns control.
interface branch_hazard_controller_if #(
    parameter int CNT_W = 16
);
    logic [1:0]       id_branch;
    logic             id_jump;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             mem_reg_write;
    logic             mem_mem_read;
    logic [4:0]       mem_rd;
    logic             wb_reg_write;
    logic [4:0]       wb_rd;
    logic             cmp_taken;
    logic             cnt_clear;

    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_bubble;
    logic             if_id_flush;
    logic             pc_sel_branch;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_branch, id_jump, id_rs, id_rt,
               ex_reg_write, ex_mem_read, ex_rd,
               mem_reg_write, mem_mem_read, mem_rd,
               wb_reg_write, wb_rd, cmp_taken, cnt_clear,
        input  pc_write, if_id_write, id_ex_bubble, if_id_flush,
               pc_sel_branch, fwd_a, fwd_b, taken_cnt, stall_cnt
    );

    modport slave (
        input  id_branch, id_jump, id_rs, id_rt,
               ex_reg_write, ex_mem_read, ex_rd,
               mem_reg_write, mem_mem_read, mem_rd,
               wb_reg_write, wb_rd, cmp_taken, cnt_clear,
        output pc_write, if_id_write, id_ex_bubble, if_id_flush,
               pc_sel_branch, fwd_a, fwd_b, taken_cnt, stall_cnt
    );

endinterface

// File: rtl/branch_hazard_controller_fwd_sel.sv
// Per-operand evaluator: picks the comparator forwarding source for one branch
// source register and reports how many stall cycles that operand still needs.
module branch_fwd_sel
    import branch_hazard_controller_pkg::*;
(
    input  logic [4:0] src_reg,
    input  logic       ex_reg_write,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic       mem_reg_write,
    input  logic       mem_mem_read,
    input  logic [4:0] mem_rd,
    input  logic       wb_reg_write,
    input  logic [4:0] wb_rd,
    output logic [1:0] fwd,
    output logic [1:0] stall_need
);
    logic nonzero;

    assign nonzero = (src_reg != 5'd0);

    // A load in EX/MEM has no ALU result yet, so it cannot feed the comparator.
    always_comb begin
        fwd = FWD_RF;
        if (nonzero && mem_reg_write && !mem_mem_read && (mem_rd == src_reg)) begin
            fwd = FWD_EXMEM;
        end else if (nonzero && wb_reg_write && (wb_rd == src_reg)) begin
            fwd = FWD_MEMWB;
        end
    end

    // The youngest producer decides: an EX writer shadows an older MEM load.
    always_comb begin
        stall_need = 2'd0;
        if (nonzero && ex_reg_write && (ex_rd == src_reg)) begin
            stall_need = ex_mem_read ? 2'd2 : 2'd1;
        end else if (nonzero && mem_reg_write && mem_mem_read && (mem_rd == src_reg)) begin
            stall_need = 2'd1;
        end
    end

endmodule

// File: rtl/branch_hazard_controller.sv
// ID-stage branch/jump sequencer: stalls for in-flight branch operands, qualifies
// the comparator result, flushes IF/ID and keeps saturating performance counters.
module branch_hazard_controller
    import branch_hazard_controller_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input logic                       clk,
    input logic                       rst_n,
    branch_hazard_controller_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    bhc_state_t       state;
    bhc_state_t       state_next;
    logic             branch_active;
    logic             stall;
    logic             resolve_taken;
    logic             jump_flush;
    logic [1:0]       need_a;
    logic [1:0]       need_b;
    logic [1:0]       need;
    logic [1:0]       fwd_a_raw;
    logic [1:0]       fwd_b_raw;
    logic [CNT_W-1:0] taken_q;
    logic [CNT_W-1:0] stall_q;

    branch_fwd_sel u_fwd_rs (
        .src_reg       (bus.id_rs),
        .ex_reg_write  (bus.ex_reg_write),
        .ex_mem_read   (bus.ex_mem_read),
        .ex_rd         (bus.ex_rd),
        .mem_reg_write (bus.mem_reg_write),
        .mem_mem_read  (bus.mem_mem_read),
        .mem_rd        (bus.mem_rd),
        .wb_reg_write  (bus.wb_reg_write),
        .wb_rd         (bus.wb_rd),
        .fwd           (fwd_a_raw),
        .stall_need    (need_a)
    );

    branch_fwd_sel u_fwd_rt (
        .src_reg       (bus.id_rt),
        .ex_reg_write  (bus.ex_reg_write),
        .ex_mem_read   (bus.ex_mem_read),
        .ex_rd         (bus.ex_rd),
        .mem_reg_write (bus.mem_reg_write),
        .mem_mem_read  (bus.mem_mem_read),
        .mem_rd        (bus.mem_rd),
        .wb_reg_write  (bus.wb_reg_write),
        .wb_rd         (bus.wb_rd),
        .fwd           (fwd_b_raw),
        .stall_need    (need_b)
    );

    assign branch_active = (bus.id_branch != 2'b00) && !bus.id_jump;
    assign need          = branch_active ? max_need(need_a, need_b) : 2'd0;

    // Mealy sequencing; everything is held inactive while reset is asserted.
    always_comb begin
        state_next    = state;
        stall         = 1'b0;
        resolve_taken = 1'b0;
        jump_flush    = 1'b0;
        if (rst_n) begin
            case (state)
                RUN: begin
                    if (bus.id_jump) begin
                        jump_flush = 1'b1;
                    end else if (need != 2'd0) begin
                        stall      = 1'b1;
                        state_next = (need == 2'd2) ? STALL : RESOLVE;
                    end else begin
                        resolve_taken = branch_active && bus.cmp_taken;
                    end
                end
                STALL: begin
                    stall      = 1'b1;
                    state_next = RESOLVE;
                end
                RESOLVE: begin
                    resolve_taken = branch_active && bus.cmp_taken;
                    state_next    = RUN;
                end
                default: state_next = RUN;
            endcase
        end
    end

    assign bus.pc_write      = !stall;
    assign bus.if_id_write   = !stall;
    assign bus.id_ex_bubble  = stall;
    assign bus.if_id_flush   = jump_flush || resolve_taken;
    assign bus.pc_sel_branch = resolve_taken;
    assign bus.fwd_a         = rst_n ? fwd_a_raw : FWD_RF;
    assign bus.fwd_b         = rst_n ? fwd_b_raw : FWD_RF;
    assign bus.taken_cnt     = taken_q;
    assign bus.stall_cnt     = stall_q;

    // Clear beats a same-cycle increment; both counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= RUN;
            taken_q <= '0;
            stall_q <= '0;
        end else begin
            state <= state_next;
            if (bus.cnt_clear) begin
                taken_q <= '0;
                stall_q <= '0;
            end else begin
                if (resolve_taken && (taken_q != CNT_MAX)) begin
                    taken_q <= taken_q + CNT_ONE;
                end
                if (stall && (stall_q != CNT_MAX)) begin
                    stall_q <= stall_q + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_hazard_controller.sv
// Self-checking bench for branch_hazard_controller: directed scenarios plus a
// randomized run against a cycle-level model of the stall/resolve rules.
module tb_branch_hazard_controller;

    logic clk = 1'b0;
    logic rst_n;
    int   checks_total  = 0;
    int   checks_passed = 0;

    branch_hazard_controller_if #(.CNT_W(16)) bus ();
    branch_hazard_controller_if #(.CNT_W(3))  bus_s ();

    branch_hazard_controller #(.CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Narrow-counter twin sharing all inputs, so saturation is reachable quickly.
    branch_hazard_controller #(.CNT_W(3)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s.slave)
    );

    assign bus_s.id_branch     = bus.id_branch;
    assign bus_s.id_jump       = bus.id_jump;
    assign bus_s.id_rs         = bus.id_rs;
    assign bus_s.id_rt         = bus.id_rt;
    assign bus_s.ex_reg_write  = bus.ex_reg_write;
    assign bus_s.ex_mem_read   = bus.ex_mem_read;
    assign bus_s.ex_rd         = bus.ex_rd;
    assign bus_s.mem_reg_write = bus.mem_reg_write;
    assign bus_s.mem_mem_read  = bus.mem_mem_read;
    assign bus_s.mem_rd        = bus.mem_rd;
    assign bus_s.wb_reg_write  = bus.wb_reg_write;
    assign bus_s.wb_rd         = bus.wb_rd;
    assign bus_s.cmp_taken     = bus.cmp_taken;
    assign bus_s.cnt_clear     = bus.cnt_clear;

    always #5 clk = ~clk;

    // {pc_write, if_id_write, id_ex_bubble, if_id_flush, pc_sel_branch, fwd_a, fwd_b}
    logic [8:0] ctl;
    assign ctl = {bus.pc_write, bus.if_id_write, bus.id_ex_bubble, bus.if_id_flush,
                  bus.pc_sel_branch, bus.fwd_a, bus.fwd_b};

    task automatic set_idle();
        bus.id_branch     = 2'b00;
        bus.id_jump       = 1'b0;
        bus.id_rs         = 5'd0;
        bus.id_rt         = 5'd0;
        bus.ex_reg_write  = 1'b0;
        bus.ex_mem_read   = 1'b0;
        bus.ex_rd         = 5'd0;
        bus.mem_reg_write = 1'b0;
        bus.mem_mem_read  = 1'b0;
        bus.mem_rd        = 5'd0;
        bus.wb_reg_write  = 1'b0;
        bus.wb_rd         = 5'd0;
        bus.cmp_taken     = 1'b0;
        bus.cnt_clear     = 1'b0;
    endtask

    task automatic clear_counters();
        set_idle();
        bus.cnt_clear = 1'b1;
        @(negedge clk);
        bus.cnt_clear = 1'b0;
    endtask

    function automatic int need_of(input logic [4:0] r);
        int n;
        n = 0;
        if (r == 5'd0) return 0;
        if (bus.ex_reg_write && bus.ex_rd == r) n = bus.ex_mem_read ? 2 : 1;
        if (bus.mem_reg_write && bus.mem_mem_read && bus.mem_rd == r && n < 1) n = 1;
        return n;
    endfunction

    function automatic logic [1:0] fwd_of(input logic [4:0] r);
        if (r == 5'd0) return 2'b00;
        if (bus.mem_reg_write && !bus.mem_mem_read && bus.mem_rd == r) return 2'b01;
        if (bus.wb_reg_write && bus.wb_rd == r) return 2'b10;
        return 2'b00;
    endfunction

    task automatic test_reset();
        bus.id_branch     = 2'b01;
        bus.id_rs         = 5'd3;
        bus.id_rt         = 5'd4;
        bus.ex_reg_write  = 1'b1;
        bus.ex_rd         = 5'd3;
        bus.mem_reg_write = 1'b1;
        bus.mem_rd        = 5'd4;
        bus.cmp_taken     = 1'b1;
        #2;
        checks_total++;
        if (ctl !== 9'b1_1_0_0_0_00_00) $display("[TB] FAIL reset_ctl got %b want %b", ctl, 9'b110000000);
        else checks_passed++;
        checks_total++;
        if ({bus.taken_cnt, bus.stall_cnt} !== 32'd0)
            $display("[TB] FAIL reset_counters got taken=%0d stall=%0d want 0/0", bus.taken_cnt, bus.stall_cnt);
        else checks_passed++;
        @(negedge clk);
        rst_n = 1'b1;
        set_idle();
        #2;
        checks_total++;
        if (ctl !== 9'b1_1_0_0_0_00_00) $display("[TB] FAIL idle_ctl got %b want %b", ctl, 9'b110000000);
        else checks_passed++;
        @(negedge clk);
    endtask

    task automatic test_no_hazard_taken();
        clear_counters();
        bus.id_branch = 2'b01;
        bus.id_rs     = 5'd1;
        bus.id_rt     = 5'd2;
        bus.cmp_taken = 1'b1;
        #2;
        checks_total++;
        if (ctl !== 9'b1_1_0_1_1_00_00) $display("[TB] FAIL taken_ctl got %b want %b", ctl, 9'b110110000);
        else checks_passed++;
        checks_total++;
        if (bus.taken_cnt !== 16'd0) $display("[TB] FAIL taken_cnt_before got %0d want 0", bus.taken_cnt);
        else checks_passed++;
        @(negedge clk);
        set_idle();
        #2;
        checks_total++;
        if ({bus.taken_cnt, bus.stall_cnt} !== {16'd1, 16'd0})
            $display("[TB] FAIL taken_cnt_after got taken=%0d stall=%0d want 1/0", bus.taken_cnt, bus.stall_cnt);
        else checks_passed++;
        @(negedge clk);
    endtask

    task automatic test_alu_hazard();
        clear_counters();
        bus.id_branch    = 2'b10;
        bus.id_rs        = 5'd3;
        bus.id_rt        = 5'd4;
        bus.ex_reg_write = 1'b1;
        bus.ex_rd        = 5'd3;
        #2;
        checks_total++;
        if (ctl !== 9'b0_0_1_0_0_00_00) $display("[TB] FAIL alu_stall_ctl got %b want %b", ctl, 9'b001000000);
        else checks_passed++;
        @(negedge clk);
        bus.ex_reg_write  = 1'b0;
        bus.ex_rd         = 5'd0;
        bus.mem_reg_write = 1'b1;
        bus.mem_rd        = 5'd3;
        #2;
        checks_total++;
        if (ctl !== 9'b1_1_0_0_0_01_00) $display("[TB] FAIL alu_resolve_ctl got %b want %b", ctl, 9'b110000100);
        else checks_passed++;
        @(negedge clk);
        set_idle();
        #2;
        checks_total++;
        if (bus.stall_cnt !== 16'd1) $display("[TB] FAIL alu_stall_cnt got %0d want 1", bus.stall_cnt);
        else checks_passed++;
        checks_total++;
        if (bus.taken_cnt !== 16'd0) $display("[TB] FAIL alu_taken_cnt got %0d want 0", bus.taken_cnt);
        else checks_passed++;
        @(negedge clk);
    endtask

    task automatic test_load_hazard();
        clear_counters();
        bus.id_branch    = 2'b01;
        bus.id_rs        = 5'd5;
        bus.id_rt        = 5'd0;
        bus.cmp_taken    = 1'b1;
        bus.ex_reg_write = 1'b1;
        bus.ex_mem_read  = 1'b1;
        bus.ex_rd        = 5'd5;
        #2;
        checks_total++;
        if (ctl !== 9'b0_0_1_0_0_00_00) $display("[TB] FAIL load_stall1_ctl got %b want %b", ctl, 9'b001000000);
        else checks_passed++;
        @(negedge clk);
        bus.ex_reg_write  = 1'b0;
        bus.ex_mem_read   = 1'b0;
        bus.ex_rd         = 5'd0;
        bus.mem_reg_write = 1'b1;
        bus.mem_mem_read  = 1'b1;
        bus.mem_rd        = 5'd5;
        #2;
        checks_total++;
        if (ctl !== 9'b0_0_1_0_0_00_00) $display("[TB] FAIL load_stall2_ctl got %b want %b", ctl, 9'b001000000);
        else checks_passed++;
        @(negedge clk);
        bus.mem_reg_write = 1'b0;
        bus.mem_mem_read  = 1'b0;
        bus.mem_rd        = 5'd0;
        bus.wb_reg_write  = 1'b1;
        bus.wb_rd         = 5'd5;
        #2;
        checks_total++;
        if (ctl !== 9'b1_1_0_1_1_10_00) $display("[TB] FAIL load_resolve_ctl got %b want %b", ctl, 9'b110111000);
        else checks_passed++;
        @(negedge clk);
        set_idle();
        #2;
        checks_total++;
        if (bus.stall_cnt !== 16'd2) $display("[TB] FAIL load_stall_cnt got %0d want 2", bus.stall_cnt);
        else checks_passed++;
        checks_total++;
        if (bus.taken_cnt !== 16'd1) $display("[TB] FAIL load_taken_cnt got %0d want 1", bus.taken_cnt);
        else checks_passed++;
        @(negedge clk);
    endtask

    task automatic test_jump_priority();
        clear_counters();
        bus.id_jump      = 1'b1;
        bus.id_branch    = 2'b01;
        bus.id_rs        = 5'd6;
        bus.id_rt        = 5'd7;
        bus.ex_reg_write = 1'b1;
        bus.ex_rd        = 5'd6;
        bus.cmp_taken    = 1'b1;
        #2;
        checks_total++;
        if (ctl !== 9'b1_1_0_1_0_00_00) $display("[TB] FAIL jump_ctl got %b want %b", ctl, 9'b110100000);
        else checks_passed++;
        @(negedge clk);
        set_idle();
        bus.id_branch = 2'b01;
        bus.id_rs     = 5'd1;
        bus.id_rt     = 5'd2;
        bus.cmp_taken = 1'b1;
        #2;
        checks_total++;
        if (ctl !== 9'b1_1_0_1_1_00_00) $display("[TB] FAIL after_jump_ctl got %b want %b", ctl, 9'b110110000);
        else checks_passed++;
        @(negedge clk);
        set_idle();
        #2;
        checks_total++;
        if ({bus.taken_cnt, bus.stall_cnt} !== {16'd1, 16'd0})
            $display("[TB] FAIL jump_counters got taken=%0d stall=%0d want 1/0", bus.taken_cnt, bus.stall_cnt);
        else checks_passed++;
        @(negedge clk);
    endtask

    task automatic test_zero_reg();
        clear_counters();
        bus.id_branch     = 2'b01;
        bus.ex_reg_write  = 1'b1;
        bus.ex_mem_read   = 1'b1;
        bus.mem_reg_write = 1'b1;
        bus.wb_reg_write  = 1'b1;
        #2;
        checks_total++;
        if (ctl !== 9'b1_1_0_0_0_00_00) $display("[TB] FAIL zero_reg_ctl got %b want %b", ctl, 9'b110000000);
        else checks_passed++;
        @(negedge clk);
        set_idle();
        #2;
        checks_total++;
        if (bus.stall_cnt !== 16'd0) $display("[TB] FAIL zero_reg_stall_cnt got %0d want 0", bus.stall_cnt);
        else checks_passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_during_stall();
        clear_counters();
        bus.id_branch    = 2'b01;
        bus.id_rs        = 5'd5;
        bus.ex_reg_write = 1'b1;
        bus.ex_mem_read  = 1'b1;
        bus.ex_rd        = 5'd5;
        bus.cmp_taken    = 1'b1;
        #2;
        checks_total++;
        if (ctl !== 9'b0_0_1_0_0_00_00) $display("[TB] FAIL rst_stall_ctl got %b want %b", ctl, 9'b001000000);
        else checks_passed++;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        checks_total++;
        if (ctl !== 9'b1_1_0_0_0_00_00) $display("[TB] FAIL rst_in_stall_ctl got %b want %b", ctl, 9'b110000000);
        else checks_passed++;
        @(negedge clk);
        rst_n = 1'b1;
        set_idle();
        bus.id_jump = 1'b1;
        #2;
        checks_total++;
        if (ctl !== 9'b1_1_0_1_0_00_00) $display("[TB] FAIL rst_back_to_run_ctl got %b want %b", ctl, 9'b110100000);
        else checks_passed++;
        checks_total++;
        if ({bus.taken_cnt, bus.stall_cnt} !== 32'd0)
            $display("[TB] FAIL rst_counters got taken=%0d stall=%0d want 0/0", bus.taken_cnt, bus.stall_cnt);
        else checks_passed++;
        @(negedge clk);
    endtask

    task automatic test_saturation();
        clear_counters();
        // Steady ALU hazard alternates stall and taken resolve: 8 of each in 16 cycles.
        bus.id_branch    = 2'b01;
        bus.id_rs        = 5'd8;
        bus.id_rt        = 5'd9;
        bus.ex_reg_write = 1'b1;
        bus.ex_rd        = 5'd8;
        bus.cmp_taken    = 1'b1;
        repeat (16) @(negedge clk);
        set_idle();
        #2;
        checks_total++;
        if (bus_s.taken_cnt !== 3'd7) $display("[TB] FAIL sat_taken_cnt got %0d want 7", bus_s.taken_cnt);
        else checks_passed++;
        checks_total++;
        if (bus_s.stall_cnt !== 3'd7) $display("[TB] FAIL sat_stall_cnt got %0d want 7", bus_s.stall_cnt);
        else checks_passed++;
        checks_total++;
        if ({bus.taken_cnt, bus.stall_cnt} !== {16'd8, 16'd8})
            $display("[TB] FAIL wide_counters got taken=%0d stall=%0d want 8/8", bus.taken_cnt, bus.stall_cnt);
        else checks_passed++;
        @(negedge clk);
    endtask

    task automatic test_clear_wins();
        clear_counters();
        bus.id_branch = 2'b01;
        bus.id_rs     = 5'd1;
        bus.id_rt     = 5'd2;
        bus.cmp_taken = 1'b1;
        @(negedge clk);
        bus.cnt_clear = 1'b1;
        #2;
        checks_total++;
        if (bus.taken_cnt !== 16'd1) $display("[TB] FAIL clear_pre_taken got %0d want 1", bus.taken_cnt);
        else checks_passed++;
        @(negedge clk);
        set_idle();
        bus.id_branch    = 2'b01;
        bus.id_rs        = 5'd3;
        bus.ex_reg_write = 1'b1;
        bus.ex_rd        = 5'd3;
        bus.cnt_clear    = 1'b1;
        #2;
        checks_total++;
        if (bus.taken_cnt !== 16'd0) $display("[TB] FAIL clear_vs_taken got %0d want 0", bus.taken_cnt);
        else checks_passed++;
        @(negedge clk);
        set_idle();
        #2;
        checks_total++;
        if (bus.stall_cnt !== 16'd0) $display("[TB] FAIL clear_vs_stall got %0d want 0", bus.stall_cnt);
        else checks_passed++;
        @(negedge clk);
    endtask

    task automatic test_random();
        int stall_left;
        bit pending;
        int m_taken;
        int m_stall;
        stall_left = 0;
        pending    = 1'b0;
        m_taken    = 0;
        m_stall    = 0;
        rst_n = 1'b0;
        set_idle();
        @(negedge clk);
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [8:0] exp_ctl;
            bit         br_act;
            bit         do_stall;
            bit         do_take;
            bit         do_jflush;
            int         need;
            rst_n             = ($urandom_range(0, 39) != 0);
            bus.id_branch     = 2'($urandom_range(0, 3));
            bus.id_jump       = ($urandom_range(0, 5) == 0);
            bus.id_rs         = 5'($urandom_range(0, 3));
            bus.id_rt         = 5'($urandom_range(0, 3));
            bus.ex_reg_write  = ($urandom_range(0, 1) == 0);
            bus.ex_mem_read   = ($urandom_range(0, 2) == 0);
            bus.ex_rd         = 5'($urandom_range(0, 3));
            bus.mem_reg_write = ($urandom_range(0, 1) == 0);
            bus.mem_mem_read  = ($urandom_range(0, 2) == 0);
            bus.mem_rd        = 5'($urandom_range(0, 3));
            bus.wb_reg_write  = ($urandom_range(0, 1) == 0);
            bus.wb_rd         = 5'($urandom_range(0, 3));
            bus.cmp_taken     = ($urandom_range(0, 1) == 0);
            bus.cnt_clear     = ($urandom_range(0, 19) == 0);
            #2;
            br_act = (bus.id_branch != 2'b00) && !bus.id_jump;
            need   = br_act ? ((need_of(bus.id_rs) > need_of(bus.id_rt)) ? need_of(bus.id_rs) : need_of(bus.id_rt)) : 0;
            do_stall  = 1'b0;
            do_take   = 1'b0;
            do_jflush = 1'b0;
            if (rst_n) begin
                if (stall_left > 0)          do_stall  = 1'b1;
                else if (pending)            do_take   = br_act && bus.cmp_taken;
                else if (bus.id_jump)        do_jflush = 1'b1;
                else if (need > 0)           do_stall  = 1'b1;
                else                         do_take   = br_act && bus.cmp_taken;
            end
            exp_ctl = {!do_stall, !do_stall, do_stall, do_jflush || do_take, do_take,
                       rst_n ? fwd_of(bus.id_rs) : 2'b00, rst_n ? fwd_of(bus.id_rt) : 2'b00};
            checks_total++;
            if (ctl !== exp_ctl) $display("[TB] FAIL rand_ctl cycle %0d got %b want %b", cyc, ctl, exp_ctl);
            else checks_passed++;
            checks_total++;
            if (bus.taken_cnt !== 16'(m_taken))
                $display("[TB] FAIL rand_taken_cnt cycle %0d got %0d want %0d", cyc, bus.taken_cnt, m_taken);
            else checks_passed++;
            checks_total++;
            if (bus.stall_cnt !== 16'(m_stall))
                $display("[TB] FAIL rand_stall_cnt cycle %0d got %0d want %0d", cyc, bus.stall_cnt, m_stall);
            else checks_passed++;
            @(posedge clk);
            if (!rst_n) begin
                stall_left = 0;
                pending    = 1'b0;
                m_taken    = 0;
                m_stall    = 0;
            end else begin
                if (bus.cnt_clear) begin
                    m_taken = 0;
                    m_stall = 0;
                end else begin
                    if (do_take && m_taken < 65535)  m_taken++;
                    if (do_stall && m_stall < 65535) m_stall++;
                end
                if (stall_left > 0) begin
                    stall_left--;
                end else if (pending) begin
                    pending = 1'b0;
                end else if (!bus.id_jump && need > 0) begin
                    stall_left = need - 1;
                    pending    = 1'b1;
                end
            end
            @(negedge clk);
        end
        rst_n = 1'b1;
        set_idle();
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        @(negedge clk);
        test_reset();
        test_no_hazard_taken();
        test_alu_hazard();
        test_load_hazard();
        test_jump_priority();
        test_zero_reg();
        test_reset_during_stall();
        test_saturation();
        test_clear_wins();
        test_random();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
